axi_stream_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one AXI-Stream datapath (e.g. a width downsizer or egress port) between NumInp requesting streams.
- A grant is locked from the first beat of a packet until the handshaked beat carrying tlast, so packets are never interleaved.
- Sits directly upstream of the shared datapath; software or a config block supplies a per-input enable mask.

---
 rtl/axi_stream_arb_pkg.sv | 32 +++
 rtl/axi_stream_pkt_arbiter_if.sv | 46 ++++
 rtl/axi_stream_rr_picker.sv | 25 ++
 rtl/axi_stream_pkt_arbiter.sv | 84 ++++++++
 tb/tb_axi_stream_pkt_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_stream_arb_pkg.sv
// Shared types and the circular first-set helper for the packet arbiter.
package axi_stream_arb_pkg;

  typedef enum logic [0:0] {StIdle, StLocked} arb_state_e;

  localparam int unsigned MaxInp  = 32;
  localparam int unsigned MaxSelW = 5;

  typedef struct packed {
    logic               found;
    logic [MaxSelW-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping at num; only the low num bits are considered.
  function automatic rr_pick_t rr_pick(input logic [MaxInp-1:0]  req,
                                       input logic [MaxSelW-1:0] ptr,
                                       input int unsigned        num);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 0; i < MaxInp; i++) begin
      j = 32'(ptr) + i;
      if (j >= num) j = j - num;
      if (i < num && !res.found && req[j[MaxSelW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[MaxSelW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_stream_pkt_arbiter_if.sv
// Bundled AXI-Stream request inputs and shared output for the packet arbiter.
interface axi_stream_pkt_arbiter_if #(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 0,
  parameter int unsigned DestWidth = 0,
  parameter int unsigned UserWidth = 0
);
  localparam int unsigned KeepWidth = DataWidth / 8;
  localparam int unsigned IdW       = (IdWidth == 0) ? 1 : IdWidth;
  localparam int unsigned DestW     = (DestWidth == 0) ? 1 : DestWidth;
  localparam int unsigned UserW     = (UserWidth == 0) ? 1 : UserWidth;

  logic [NumInp-1:0]           inp_tvalid_i;
  logic [NumInp-1:0]           inp_tready_o;
  logic [NumInp*DataWidth-1:0] inp_tdata_i;
  logic [NumInp*KeepWidth-1:0] inp_tkeep_i;
  logic [NumInp-1:0]           inp_tlast_i;
  logic [NumInp*IdW-1:0]       inp_tid_i;
  logic [NumInp*DestW-1:0]     inp_tdest_i;
  logic [NumInp*UserW-1:0]     inp_tuser_i;

  logic                        out_tvalid_o;
  logic                        out_tready_i;
  logic [DataWidth-1:0]        out_tdata_o;
  logic [KeepWidth-1:0]        out_tkeep_o;
  logic                        out_tlast_o;
  logic [IdW-1:0]              out_tid_o;
  logic [DestW-1:0]            out_tdest_o;
  logic [UserW-1:0]            out_tuser_o;

  modport slave (
    input  inp_tvalid_i, inp_tdata_i, inp_tkeep_i, inp_tlast_i, inp_tid_i, inp_tdest_i,
           inp_tuser_i, out_tready_i,
    output inp_tready_o, out_tvalid_o, out_tdata_o, out_tkeep_o, out_tlast_o, out_tid_o,
           out_tdest_o, out_tuser_o
  );

  modport master (
    output inp_tvalid_i, inp_tdata_i, inp_tkeep_i, inp_tlast_i, inp_tid_i, inp_tdest_i,
           inp_tuser_i, out_tready_i,
    input  inp_tready_o, out_tvalid_o, out_tdata_o, out_tkeep_o, out_tlast_o, out_tid_o,
           out_tdest_o, out_tuser_o
  );

endinterface

// File: rtl/axi_stream_rr_picker.sv
// Combinational circular priority encoder: first request at or after ptr_i.
module axi_stream_rr_picker
  import axi_stream_arb_pkg::*;
#(
  parameter  int unsigned NumInp   = 4,
  localparam int unsigned SelWidth = (NumInp > 2) ? $clog2(NumInp) : 1
) (
  input  logic [NumInp-1:0]   req_i,
  input  logic [SelWidth-1:0] ptr_i,
  output logic                found_o,
  output logic [SelWidth-1:0] idx_o
);

  rr_pick_t pick;
  logic     unused_idx;

  always_comb begin
    pick    = rr_pick(MaxInp'(req_i), MaxSelW'(ptr_i), NumInp);
    found_o = pick.found;
    idx_o   = pick.idx[SelWidth-1:0];
  end

  assign unused_idx = ^pick.idx;

endmodule

// File: rtl/axi_stream_pkt_arbiter.sv
// Packet-level round-robin arbiter: locks one input onto the shared stream until tlast.
module axi_stream_pkt_arbiter
  import axi_stream_arb_pkg::*;
#(
  parameter  int unsigned NumInp    = 4,
  parameter  int unsigned DataWidth = 32,
  parameter  int unsigned IdWidth   = 0,
  parameter  int unsigned DestWidth = 0,
  parameter  int unsigned UserWidth = 0,
  localparam int unsigned SelWidth  = (NumInp > 2) ? $clog2(NumInp) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumInp-1:0]     inp_en_i,
  output logic [SelWidth-1:0]   sel_o,
  output logic                  busy_o,
  axi_stream_pkt_arbiter_if.slave axis_io
);

  localparam int unsigned KeepWidth = DataWidth / 8;
  localparam int unsigned IdW       = (IdWidth == 0) ? 1 : IdWidth;
  localparam int unsigned DestW     = (DestWidth == 0) ? 1 : DestWidth;
  localparam int unsigned UserW     = (UserWidth == 0) ? 1 : UserWidth;

  arb_state_e          state_q;
  logic [SelWidth-1:0] sel_q, rr_ptr_q;
  logic [NumInp-1:0]   req;
  logic                pick_found, locked, out_hs_last;
  logic [SelWidth-1:0] pick_idx;

  assign req = axis_io.inp_tvalid_i & inp_en_i;

  axi_stream_rr_picker #(
    .NumInp (NumInp)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Reset gates the passthrough so no beat handshakes in the reset cycle.
  assign locked      = (state_q == StLocked) && !rst_i;
  assign busy_o      = locked;
  assign sel_o       = sel_q;
  assign out_hs_last = axis_io.out_tvalid_o & axis_io.out_tready_i & axis_io.out_tlast_o;

  always_comb begin
    axis_io.inp_tready_o        = '0;
    axis_io.inp_tready_o[sel_q] = locked & axis_io.out_tready_i;
    axis_io.out_tvalid_o        = locked & axis_io.inp_tvalid_i[sel_q];
    axis_io.out_tdata_o         = axis_io.inp_tdata_i[sel_q*DataWidth +: DataWidth];
    axis_io.out_tkeep_o         = axis_io.inp_tkeep_i[sel_q*KeepWidth +: KeepWidth];
    axis_io.out_tlast_o         = axis_io.inp_tlast_i[sel_q];
    axis_io.out_tid_o   = (IdWidth == 0)   ? '0 : axis_io.inp_tid_i[sel_q*IdW +: IdW];
    axis_io.out_tdest_o = (DestWidth == 0) ? '0 : axis_io.inp_tdest_i[sel_q*DestW +: DestW];
    axis_io.out_tuser_o = (UserWidth == 0) ? '0 : axis_io.inp_tuser_i[sel_q*UserW +: UserW];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            sel_q   <= pick_idx;
            state_q <= StLocked;
          end
        end
        StLocked: begin
          if (out_hs_last) begin
            state_q  <= StIdle;
            rr_ptr_q <= (sel_q == SelWidth'(NumInp - 1)) ? '0 : sel_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_pkt_arbiter.sv
// Randomized and directed bench for axi_stream_pkt_arbiter against a packet-queue reference model.
module tb_axi_stream_pkt_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic [1:0] sel;
  logic       busy;

  axi_stream_pkt_arbiter_if #(.NumInp(N), .DataWidth(32)) axis_if ();

  axi_stream_pkt_arbiter #(.NumInp(N), .DataWidth(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .inp_en_i (en),
    .sel_o    (sel),
    .busy_o   (busy),
    .axis_io  (axis_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [31:0] q_data[N][$];
  logic [3:0]  q_keep[N][$];
  bit          q_last[N][$];
  bit          act[N];
  int          sent[N];
  int          vprob, rprob, owner_m, ptr_m;
  bit          tready, prev_busy, chk_sel0, rnd_en, rst_hook;
  bit          bp_armed, rst_armed, clr_armed;
  int          tr_pat[$];
  int          dut_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] req);
    for (int i = 0; i < N; i++) begin
      int j = (ptr_m + i) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic push_pkt(input int k, input int beats, input logic [31:0] base, input bit rnd);
    for (int b = 0; b < beats; b++) begin
      q_data[k].push_back(rnd ? $urandom : base + b);
      q_keep[k].push_back(4'($urandom_range(0, 15)));
      q_last[k].push_back(b == beats - 1);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bit has = q_data[k].size() > 0;
      axis_if.inp_tvalid_i[k]         = act[k] && has;
      axis_if.inp_tdata_i[k*32 +: 32] = has ? q_data[k][0] : $urandom;
      axis_if.inp_tkeep_i[k*4 +: 4]   = has ? q_keep[k][0] : 4'($urandom);
      axis_if.inp_tlast_i[k]          = has ? q_last[k][0] : 1'b0;
    end
    axis_if.inp_tid_i    = 4'($urandom);
    axis_if.inp_tdest_i  = 4'($urandom);
    axis_if.inp_tuser_i  = 4'($urandom);
    axis_if.out_tready_i = tready;
  endtask

  task automatic cycle();
    int o;
    logic [3:0] exp_rdy, vld;
    bit exp_v, hs, lst;
    @(negedge clk);
    vld = axis_if.inp_tvalid_i;
    o = owner_m;
    exp_rdy = '0;
    exp_v = 1'b0;
    if (!rst && o >= 0) begin
      exp_v = vld[o];
      exp_rdy[o] = tready;
    end
    check("tready", 64'(axis_if.inp_tready_o), 64'(exp_rdy));
    check("tvalid", 64'(axis_if.out_tvalid_o), 64'(exp_v));
    check("busy", 64'(busy), 64'(!rst && o >= 0));
    if (!rst && o >= 0) check("sel", 64'(sel), 64'(o));
    if (exp_v) begin
      check("tdata", 64'(axis_if.out_tdata_o), 64'(q_data[o][0]));
      check("tkeep", 64'(axis_if.out_tkeep_o), 64'(q_keep[o][0]));
      check("tlast", 64'(axis_if.out_tlast_o), 64'(q_last[o][0]));
      check("side", 64'({axis_if.out_tid_o, axis_if.out_tdest_o, axis_if.out_tuser_o}), 64'(0));
    end
    if (chk_sel0) begin
      check("sel_after_rst", 64'(sel), 64'(0));
      chk_sel0 = 1'b0;
    end
    if (busy && !prev_busy) dut_log.push_back(int'(sel));
    prev_busy = busy;
    hs = exp_v && tready;
    @(posedge clk);
    for (int k = 0; k < N; k++)
      if (!(vld[k] && !(hs && k == o))) act[k] = $urandom_range(0, 99) < vprob;
    if (rst) begin
      owner_m = -1;
      ptr_m = 0;
      chk_sel0 = 1'b1;
      for (int k = 0; k < N; k++) begin
        q_data[k].delete(); q_keep[k].delete(); q_last[k].delete();
        act[k] = 1'b0; sent[k] = 0;
      end
    end else if (o < 0) begin
      if ((vld & en) != 0) owner_m = pick(vld & en);
    end else if (hs) begin
      lst = q_last[o][0];
      void'(q_data[o].pop_front()); void'(q_keep[o].pop_front()); void'(q_last[o].pop_front());
      sent[o]++;
      if (lst) begin
        ptr_m = (o + 1) % N;
        owner_m = -1;
        sent[o] = 0;
      end
    end
    #1;
    if (rst_hook) begin rst = 1'b0; rst_hook = 1'b0; end
    if (rst_armed && owner_m == 2 && sent[2] == 1) begin
      rst = 1'b1; rst_hook = 1'b1; rst_armed = 1'b0;
    end
    if (clr_armed && owner_m == 1 && sent[1] >= 1) begin en[1] = 1'b0; clr_armed = 1'b0; end
    if (bp_armed && owner_m >= 0) begin tr_pat = {1, 0, 0, 1}; bp_armed = 1'b0; end
    if (rnd_en && $urandom_range(0, 9) == 0) en = 4'($urandom);
    if (tr_pat.size() > 0) tready = tr_pat.pop_front() != 0;
    else tready = $urandom_range(0, 99) < rprob;
    drive();
  endtask

  task automatic run_until(input logic [3:0] mask, input int limit);
    int rem;
    for (int c = 0; c < limit; c++) begin
      rem = 0;
      for (int k = 0; k < N; k++) if (mask[k]) rem += q_data[k].size();
      if (rem == 0 && owner_m < 0) break;
      cycle();
    end
    rem = 0;
    for (int k = 0; k < N; k++) if (mask[k]) rem += q_data[k].size();
    check("drain", 64'(rem), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    cycle();
    rst = 1'b0;
    drive();
  endtask

  task automatic check_log(input string tag, input int exp[$]);
    check({tag, "_count"}, 64'(dut_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
      check(tag, 64'(dut_log[i]), 64'(exp[i]));
    dut_log.delete();
  endtask

  initial begin
    rst = 1'b1; en = 4'hF; tready = 1'b1; vprob = 100; rprob = 100;
    owner_m = -1; ptr_m = 0;
    for (int k = 0; k < N; k++) begin act[k] = 1'b0; sent[k] = 0; end
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    dut_log.delete();

    // Lone requester on input 2, four beats.
    push_pkt(2, 4, 32'hA0, 1'b0); act[2] = 1'b1; drive();
    run_until(4'b0100, 50);
    check_log("single", {2});

    // Pointer now sits at 3: inputs 3 then 1 are served.
    push_pkt(1, 2, 32'h100, 1'b0); push_pkt(3, 2, 32'h300, 1'b0);
    act[1] = 1'b1; act[3] = 1'b1; drive();
    run_until(4'b1010, 50);
    check_log("wrap", {3, 1});

    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < N; k++) push_pkt(k, 2, 32'(k << 8 | p << 4), 1'b0);
    for (int k = 0; k < N; k++) act[k] = 1'b1;
    drive();
    run_until(4'hF, 100);
    check_log("rr", {0, 1, 2, 3, 0, 1, 2, 3});

    en = 4'b1010;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < N; k++) push_pkt(k, 3, 32'(k << 8 | p << 4), 1'b0);
    drive();
    run_until(4'b1010, 100);
    check_log("mask", {1, 3, 1, 3});

    push_pkt(1, 4, 32'hB0, 1'b0); clr_armed = 1'b1; drive();
    run_until(4'b0010, 50);
    check_log("mask_clear", {1});

    do_reset();
    en = 4'b0100;
    push_pkt(2, 3, 32'hC0, 1'b0); bp_armed = 1'b1; drive();
    run_until(4'b0100, 50);
    check_log("bp", {2});

    push_pkt(2, 4, 32'hD0, 1'b0); rst_armed = 1'b1; drive();
    run_until(4'b0100, 50);
    check("rst_fired", 64'(rst_armed), 64'(0));
    dut_log.delete();
    en = 4'hF;
    for (int k = 0; k < N; k++) push_pkt(k, 1, 32'(k), 1'b0);
    drive();
    run_until(4'hF, 50);
    check_log("post_rst", {0, 1, 2, 3});

    vprob = 60; rprob = 70; rnd_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0)
        push_pkt($urandom_range(0, N - 1), $urandom_range(1, 5), 32'h0, 1'b1);
      cycle();
    end
    rnd_en = 1'b0; en = 4'hF;
    run_until(4'hF, 3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
